// File: rtl/sprite_scheduler.sv
// rtl/sprite_scheduler.sv - shares one 90x90 sprite-sheet ROM between NUM_SPRITES on-screen sprites
//
// Ports:
//   vga_clk      pixel clock, all logic on posedge
//   reset        asynchronous, active-high
//   DrawX/DrawY  current pixel column/row
//   blank        1 = visible region
//   sprite_x/y   packed centre positions, sprite i at bits [10i+9:10i]
//   sprite_en    per-sprite enable
//   rom_address  registered ROM address for the winning sprite
//   rom_q        ROM texel, valid ROM_LAT cycles after rom_address
//   pix_valid    visible, opaque sprite pixel
//   pix_idx      palette index (0 when pix_valid=0)
//   pix_id       winning sprite index
//   collision    boxes of two or more sprites overlapped in the previous frame
module sprite_scheduler #(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_DIM     = 90,
  parameter int SPR_HALF    = 45,
  parameter int ADDR_W      = 13,
  parameter int IDX_W       = 3,
  parameter int TRANSP_IDX  = 0,
  parameter int ROM_LAT     = 1,
  parameter int LATCH_Y     = 480,
  localparam int ID_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                      vga_clk,
  input  logic                      reset,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      blank,
  input  logic [10*NUM_SPRITES-1:0] sprite_x,
  input  logic [10*NUM_SPRITES-1:0] sprite_y,
  input  logic [NUM_SPRITES-1:0]    sprite_en,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [IDX_W-1:0]          rom_q,
  output logic                      pix_valid,
  output logic [IDX_W-1:0]          pix_idx,
  output logic [ID_W-1:0]           pix_id,
  output logic                      collision
);

  // Shadow copies of sprite state, reloaded once per frame.
  logic [9:0]             r_sx [NUM_SPRITES];
  logic [9:0]             r_sy [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] r_en;
  logic                   r_acc;

  logic                   r_hit0;
  logic [ID_W-1:0]        r_id0;
  logic                   r_hit_d [ROM_LAT];
  logic [ID_W-1:0]        r_id_d  [ROM_LAT];

  logic                   w_latch;
  logic signed [10:0]     w_dx [NUM_SPRITES];
  logic signed [10:0]     w_dy [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] w_in;
  logic [ID_W-1:0]        w_win;
  logic                   w_multi;
  logic [ADDR_W-1:0]      w_addr;
  logic                   w_opaque;

  assign w_latch = (DrawX == 10'd0) && (DrawY == 10'(LATCH_Y));

  // Box offsets in 11-bit two's complement; a negative result (bit 10 set)
  // means the pixel is left of / above the box, so edge sprites clip instead
  // of wrapping around the screen.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_dx[i] = 11'(DrawX) - 11'(r_sx[i]) + 11'(SPR_HALF);
      w_dy[i] = 11'(DrawY) - 11'(r_sy[i]) + 11'(SPR_HALF);
      w_in[i] = r_en[i]
              && !w_dx[i][10] && (w_dx[i][9:0] < 10'(SPR_DIM))
              && !w_dy[i][10] && (w_dy[i][9:0] < 10'(SPR_DIM));
    end
  end

  // Scan from lowest priority up so the lowest covering index wins.
  always_comb begin
    w_win = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_in[i]) w_win = ID_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign w_multi = (w_in & (w_in - 1'b1)) != '0;

  assign w_addr = (|w_in)
                ? ADDR_W'(w_dy[w_win][9:0]) * ADDR_W'(SPR_DIM) + ADDR_W'(w_dx[w_win][9:0])
                : '0;

  assign w_opaque = r_hit_d[ROM_LAT-1] && (rom_q != IDX_W'(TRANSP_IDX));

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_sx[i] <= '0;
        r_sy[i] <= '0;
      end
      r_en      <= '0;
      r_acc     <= 1'b0;
      collision <= 1'b0;
    end else if (w_latch) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_sx[i] <= sprite_x[10*i +: 10];
        r_sy[i] <= sprite_y[10*i +: 10];
      end
      r_en      <= sprite_en;
      collision <= r_acc;
      r_acc     <= 1'b0;
    end else if (blank && w_multi) begin
      r_acc <= 1'b1;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address <= '0;
      r_hit0      <= 1'b0;
      r_id0       <= '0;
      for (int k = 0; k < ROM_LAT; k++) begin
        r_hit_d[k] <= 1'b0;
        r_id_d[k]  <= '0;
      end
      pix_valid <= 1'b0;
      pix_idx   <= '0;
      pix_id    <= '0;
    end else begin
      rom_address <= w_addr;
      r_hit0      <= (|w_in) && blank;
      r_id0       <= w_win;
      // Hit/ID ride alongside the ROM read so they line up with rom_q.
      r_hit_d[0]  <= r_hit0;
      r_id_d[0]   <= r_id0;
      for (int k = 1; k < ROM_LAT; k++) begin
        r_hit_d[k] <= r_hit_d[k-1];
        r_id_d[k]  <= r_id_d[k-1];
      end
      // A transparent texel of the winner stays transparent; lower sprites
      // are never consulted.
      pix_valid <= w_opaque;
      pix_idx   <= w_opaque ? rom_q : '0;
      pix_id    <= r_hit_d[ROM_LAT-1] ? r_id_d[ROM_LAT-1] : '0;
    end
  end

endmodule

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
- Shares one sprite-sheet ROM (90x90 texels, 3-bit palette index) between NUM_SPRITES on-screen instances.
- Per pixel: picks the highest-priority enabled sprite covering (DrawX, DrawY), generates the ROM address, and delay-matches the ROM output. Emits palette index plus hit and sprite ID to the colour-mapper stage.
- Sprite positions are double-buffered per frame so that no image tearing occurs. Sprite-box collisions are reported per frame.

Parameters:
- NUM_SPRITES, 4, number of sprite instances; index 0 has highest priority.
- SPR_DIM, 90, sprite width and height in pixels.
- SPR_HALF, 45, centre offset; a sprite at position (X,Y) covers X-45..X+44 and Y-45..Y+44.
- ADDR_W, 13, ROM address width.
- IDX_W, 3, palette index width.
- TRANSP_IDX, 0, palette index treated as transparent.
- ROM_LAT, 1, ROM read latency in vga_clk cycles (1..3).
- LATCH_Y, 480, DrawY value at which shadow positions load.

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = visible region (display enable).
- sprite_x  in  10*NUM_SPRITES  packed centre X; sprite i occupies bits [10i+9:10i].
- sprite_y  in  10*NUM_SPRITES  packed centre Y.
- sprite_en  in  NUM_SPRITES  per-sprite enable.
- rom_address  out  ADDR_W  registered ROM address.
- rom_q  in  IDX_W  ROM data, valid ROM_LAT cycles after rom_address.
- pix_valid  out  1  output pixel is visible and opaque sprite.
- pix_idx  out  IDX_W  palette index (0 when pix_valid=0).
- pix_id  out  $clog2(NUM_SPRITES)  winning sprite index.
- collision  out  1  sticky flag: boxes of two or more enabled sprites overlapped on a visible pixel in the previous frame.

Behaviour:
- Reset (async, active-high) clears:
  - all shadow positions and shadow enables to 0;
  - all pipeline stages;
  - rom_address, pix_valid, pix_idx, pix_id, collision, and the internal collision accumulator.
- Shadow latch:
  - Occurs on the cycle where DrawX==0 and DrawY==LATCH_Y.
  - Shadow registers load sprite_x, sprite_y and sprite_en.
  - Same cycle: collision <= accumulator, and the accumulator clears.
  - Outside that cycle, shadow registers hold.
  - Consequence: after reset, no sprite is drawn until the first latch.
- Stage 0 (registered at t+1):
  - Per sprite i, using signed 11-bit arithmetic: dx = DrawX - sx_i + SPR_HALF, dy = DrawY - sy_i + SPR_HALF.
  - in_i = en_i and 0 <= dx < SPR_DIM and 0 <= dy < SPR_DIM.
  - Sprites near screen edges (sx < 45 or sx > 595) must clip correctly, with no wrap.
  - Winner = lowest i with in_i.
  - rom_address <= dy*SPR_DIM + dx for the winner, else 0. The product is computed at ADDR_W width, maximum 8099.
  - Stage flags carried forward: hit0 = any in_i and blank; id0 = winner.
- Delay line:
  - hit and id are delayed ROM_LAT cycles so they align with rom_q.
- Output stage (registered at t+2+ROM_LAT, i.e. 3 cycles for the default):
  - pix_valid <= hit_d and (rom_q != TRANSP_IDX).
  - pix_idx <= rom_q if pix_valid else 0.
  - pix_id <= id_d if hit_d else 0.
  - A transparent texel of the winning sprite does not fall through to lower-priority sprites.
- Collision accumulator:
  - Sets when blank=1 and two or more in_i are true in stage 0.
  - Sticky until the next latch.
- blank=0 forces hit0=0. rom_address is still generated, harmlessly.
- Pipeline is free-running: one pixel per cycle, no stalls, no back-pressure.

Test Plan:
- Reset mid-frame with sprite_en=4'b0001 at (100,100) → all outputs 0. No pixel is valid until after DrawY=480, DrawX=0; in the next frame pixel (55,55) yields rom_address=0 at t+1 and pix_valid at t+3.
- Sprite 0 at (320,240), ROM model returns addr[2:0] with ROM_LAT=1:
  - pixel (275,195) → address 0;
  - pixel (364,284) → address 8099;
  - pixel (365,240) → no hit.
- Sprites 0 and 1 both at (200,200), pixel (200,200) → pix_id=0 and address 4095. collision stays 0 until the next latch, then reads 1, then clears after a frame without overlap.
- Sprite 0 at (20,20), pixel (0,0) → dx=25, dy=25, address 2275. Pixel (639,0) → no hit (no wrap).
- ROM returns TRANSP_IDX at sprite 0's texel while sprite 1 also covers the pixel → pix_valid=0, pix_idx=0.
- sprite_x changed mid-frame (DrawY=100) → output is unchanged until DrawY=480. Repeat with ROM_LAT=3 → output latency is 5 cycles.
